// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state encoding
package uart_pkg;

    localparam int UART_CLKS_PER_BIT  = 104;
    localparam int UART_BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter with end-of-bit tick
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // restart wins over en so a new frame always begins on a full bit period
    always_comb begin
        cnt_d   = cnt_q;
        bit_end = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                bit_end = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_two_byte.sv
// rtl/uart_tx_two_byte.sv - edge-triggered 8N1 transmitter for a two-byte response
module uart_tx_two_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    uart_state_e state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        byte_idx_q, byte_idx_d;
    logic        start_prev_q, start_prev_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        trigger;
    logic        bit_end;

    assign trigger = (state_q == ST_IDLE) && start && !start_prev_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q != ST_IDLE),
        .restart(trigger),
        .bit_end(bit_end)
    );

    // tx_d is computed for the state being entered so the line flop changes
    // on the same edge as the state register
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        start_prev_d = start;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (trigger) begin
                    shift_d    = {byte1, byte0};
                    byte_idx_d = 1'b0;
                    bit_idx_d  = 3'd0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[15:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(UART_BITS_PER_BYTE - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // start_prev resets high so a request already asserted at reset release is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= 1'b0;
            start_prev_q <= 1'b1;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            start_prev_q <= start_prev_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_two_byte.sv
// tb/tb_uart_tx_two_byte.sv - scoreboard bench for the two-byte UART transmitter
module tb_uart_tx_two_byte;

    localparam int CPB       = 104;
    localparam int NBITS     = 20;
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] byte0 = 8'h00;
    logic [7:0] byte1 = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] exp_q[$];

    logic [19:0] obs_word;
    int          done_k;
    int          done_cnt;
    logic        busy_all;
    logic        busy_end;
    logic        tx_end;

    uart_tx_two_byte #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .byte0(byte0),
        .byte1(byte1),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 cycles, required to finish earlier");
        $fatal(1, "timeout");
    end

    // Bit 0 of the word is the first bit on the line (start bit of byte0)
    function automatic logic [19:0] frame_bits(input logic [7:0] b0, input logic [7:0] b1);
        return {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
    endfunction

    // Samples tx at the first, middle and last cycle of every bit; a bit whose
    // three samples disagree is recorded as X. k counts cycles after the trigger.
    task automatic capture(input int ncyc);
        logic f[NBITS];
        logic m[NBITS];
        done_k   = -1;
        done_cnt = 0;
        busy_all = 1'b1;
        busy_end = 1'bx;
        tx_end   = 1'bx;
        obs_word = 'x;
        for (int k = 1; k <= ncyc; k++) begin
            int b;
            int off;
            @(negedge clk);
            b   = (k - 1) / CPB;
            off = (k - 1) % CPB;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k <= FRAME_CYC) begin
                if (off == 0) f[b] = tx;
                if (off == CPB / 2) begin
                    m[b] = tx;
                    if (busy !== 1'b1) busy_all = 1'b0;
                end
                if (off == CPB - 1) obs_word[b] = (f[b] === m[b] && m[b] === tx) ? tx : 1'bx;
            end else if (k == FRAME_CYC + 1) begin
                busy_end = busy;
                tx_end   = tx;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [19:0] exp;
        exp_q.push_back(frame_bits(8'h01, 8'hA5));
        byte0 = 8'h01;
        byte1 = 8'hA5;
        start = 1'b1;
        fork
            capture(FRAME_CYC + 6);
            begin repeat (103) @(negedge clk); start = 1'b0; end
        join
        exp = exp_q.pop_front();
        n_cmp++; if (obs_word !== exp) begin n_bad++; $display("FAIL basic_frame: got %b want %b", obs_word, exp); end
        n_cmp++; if (done_k !== FRAME_CYC + 1) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_k, FRAME_CYC + 1); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_all !== 1'b1) begin n_bad++; $display("FAIL basic_busy_in_frame: got %b want 1", busy_all); end
        n_cmp++; if (busy_end !== 1'b0 || tx_end !== 1'b1) begin n_bad++; $display("FAIL basic_idle_after: busy=%b tx=%b want busy=0 tx=1", busy_end, tx_end); end
    endtask

    task automatic test_held_start();
        int bad_tx;
        int bad_busy;
        bad_tx   = 0;
        bad_busy = 0;
        rst_n = 1'b0;
        start = 1'b1;
        byte0 = 8'h5A;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        n_cmp++; if (bad_tx !== 0) begin n_bad++; $display("FAIL held_start_tx: %0d cycles not idle, want 0", bad_tx); end
        n_cmp++; if (bad_busy !== 0) begin n_bad++; $display("FAIL held_start_busy: %0d cycles busy, want 0", bad_busy); end
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_ignore_retrigger();
        logic [19:0] exp;
        exp_q.push_back(frame_bits(8'h3C, 8'h5A));
        byte0 = 8'h3C;
        byte1 = 8'h5A;
        start = 1'b1;
        fork
            capture(FRAME_CYC + 6);
            begin
                repeat (50) @(negedge clk);
                start = 1'b0;
                repeat (450) @(negedge clk);
                start = 1'b1;
                byte0 = 8'hFF;
                byte1 = 8'h00;
                repeat (20) @(negedge clk);
                start = 1'b0;
            end
        join
        exp = exp_q.pop_front();
        n_cmp++; if (obs_word !== exp) begin n_bad++; $display("FAIL ignore_frame: got %b want %b", obs_word, exp); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (done_k !== FRAME_CYC + 1) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d want %0d", done_k, FRAME_CYC + 1); end
    endtask

    task automatic test_byte_change();
        logic [19:0] exp;
        exp_q.push_back(frame_bits(8'h01, 8'h77));
        byte0 = 8'h01;
        byte1 = 8'h77;
        start = 1'b1;
        fork
            capture(FRAME_CYC + 6);
            begin
                repeat (10) @(negedge clk);
                byte0 = 8'hFF;
                byte1 = 8'h00;
                repeat (40) @(negedge clk);
                start = 1'b0;
            end
        join
        exp = exp_q.pop_front();
        n_cmp++; if (obs_word !== exp) begin n_bad++; $display("FAIL byte_change_frame: got %b want %b", obs_word, exp); end
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp;
        byte0 = 8'h00;
        byte1 = 8'hFF;
        start = 1'b1;
        repeat (50) @(negedge clk);
        start = 1'b0;
        repeat (450) @(negedge clk);
        // cycle 500 after the trigger lies in byte0 data bit 3, which is 0
        n_cmp++; if (tx !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_precheck: tx=%b busy=%b want tx=0 busy=1", tx, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(frame_bits(8'h96, 8'h3C));
        byte0 = 8'h96;
        byte1 = 8'h3C;
        start = 1'b1;
        fork
            capture(FRAME_CYC + 6);
            begin repeat (50) @(negedge clk); start = 1'b0; end
        join
        exp = exp_q.pop_front();
        n_cmp++; if (obs_word !== exp) begin n_bad++; $display("FAIL mid_reset_refire_frame: got %b want %b", obs_word, exp); end
        n_cmp++; if (done_k !== FRAME_CYC + 1) begin n_bad++; $display("FAIL mid_reset_refire_done: got %0d want %0d", done_k, FRAME_CYC + 1); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        exp_q.push_back(frame_bits(8'hA5, 8'h5A));
        exp_q.push_back(frame_bits(8'h00, 8'hFF));
        byte0 = 8'hA5;
        byte1 = 8'h5A;
        start = 1'b1;
        fork
            capture(FRAME_CYC + 1);
            begin repeat (50) @(negedge clk); start = 1'b0; end
        join
        exp = exp_q.pop_front();
        n_cmp++; if (obs_word !== exp) begin n_bad++; $display("FAIL b2b_first_frame: got %b want %b", obs_word, exp); end
        n_cmp++; if (done_k !== FRAME_CYC + 1) begin n_bad++; $display("FAIL b2b_first_done: got %0d want %0d", done_k, FRAME_CYC + 1); end
        @(negedge clk);
        byte0 = 8'h00;
        byte1 = 8'hFF;
        start = 1'b1;
        fork
            capture(FRAME_CYC + 6);
            begin repeat (50) @(negedge clk); start = 1'b0; end
        join
        exp = exp_q.pop_front();
        n_cmp++; if (obs_word !== exp) begin n_bad++; $display("FAIL b2b_second_frame: got %b want %b", obs_word, exp); end
        n_cmp++; if (done_k !== FRAME_CYC + 1) begin n_bad++; $display("FAIL b2b_second_done: got %0d want %0d", done_k, FRAME_CYC + 1); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL b2b_second_done_count: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_start();
        test_ignore_retrigger();
        test_byte_change();
        test_reset_mid();
        test_back_to_back();
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d frames left, want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
